// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared state encoding, divide op codes and counter sizing
// for the divider writeback sequencing controller.
`default_nettype none

package div_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WB   = 2'd2
  } div_state_e;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  localparam int XLEN_DEFAULT    = 32;
  localparam int DIV_LAT_DEFAULT = 33;
  localparam int DIV_LAT_MIN     = 2;
  localparam int DIV_LAT_MAX     = 63;
  localparam int CNT_W           = $clog2(DIV_LAT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

`default_nettype wire

// File: rtl/div_hazard_unit.sv
// div_hazard_unit: flags an ID instruction that touches the pending divide
// destination (RAW/WAW) or is itself a divide. x0 never creates a hazard.
`default_nettype none

module div_hazard_unit (
  input  logic [4:0] recon_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic [4:0] id_rd_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  input  logic       id_wr_en_i,
  input  logic       id_is_div_i,
  output logic       hz_o
);

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_rd_hit;

  assign w_rs1_hit = id_rs1_used_i && (id_rs1_i == recon_rd_i);
  assign w_rs2_hit = id_rs2_used_i && (id_rs2_i == recon_rd_i);
  assign w_rd_hit  = id_wr_en_i    && (id_rd_i  == recon_rd_i);

  assign hz_o = (recon_rd_i != 5'd0) &&
                (w_rs1_hit || w_rs2_hit || w_rd_hit || id_is_div_i);

endmodule

`default_nettype wire

// File: rtl/div_wb_ctrl.sv
// div_wb_ctrl: launches the multi-cycle divider, counts its latency and claims
// one EX/MEM slot for writeback. DIV_OVERLAP_EN lets independent work flow.
`default_nettype none

module div_wb_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEFAULT,
  parameter int XLEN    = XLEN_DEFAULT
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       ex_div_valid,
  input  logic [1:0] ex_div_op,
  input  logic [4:0] ex_div_rd,
  input  logic       ex_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] id_rd,
  input  logic       id_wr_en,
  input  logic       id_is_div,
  output logic       div_start,
  output logic [1:0] div_op,
  output logic       IDiv,
  output logic       div_done,
  output logic [4:0] recon_rd,
  output logic       div_busy,
  output logic       stall
);

  if ((DIV_LAT < DIV_LAT_MIN) || (DIV_LAT > DIV_LAT_MAX) || (XLEN < 1)) begin : g_param_check
    $error("div_wb_ctrl: DIV_LAT must lie in 2..63 and XLEN must be positive");
  end

  localparam cnt_t CNT_LOAD = cnt_t'(DIV_LAT - 1);

  div_state_e state_q;
  cnt_t       cnt_q;
  logic [4:0] recon_rd_q;
  logic [1:0] div_op_q;
  logic       div_done_q;
  logic       div_busy_q;

  logic       w_start;

  assign w_start = (state_q == S_IDLE) && ex_div_valid;

  // Outputs other than the launch pulse and stall are registered alongside state.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      recon_rd_q <= '0;
      div_op_q   <= '0;
      div_done_q <= 1'b0;
      div_busy_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_start) begin
            recon_rd_q <= ex_div_rd;
            div_op_q   <= ex_div_op;
            cnt_q      <= CNT_LOAD;
            div_busy_q <= 1'b1;
            state_q    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_q == '0) begin
            div_done_q <= 1'b1;
            state_q    <= S_WB;
          end else begin
            cnt_q <= cnt_q - cnt_t'(1);
          end
        end
        S_WB: begin
          div_done_q <= 1'b0;
          div_busy_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          div_done_q <= 1'b0;
          div_busy_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign div_start = w_start;
  assign IDiv      = w_start;
  assign div_op    = div_op_q;
  assign recon_rd  = recon_rd_q;
  assign div_done  = div_done_q;
  assign div_busy  = div_busy_q;

`ifdef DIV_OVERLAP_EN
  logic w_hz;
  logic w_active;

  div_hazard_unit u_hazard (
    .recon_rd_i    (recon_rd_q),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_rd_i       (id_rd),
    .id_rs1_used_i (id_rs1_used),
    .id_rs2_used_i (id_rs2_used),
    .id_wr_en_i    (id_wr_en),
    .id_is_div_i   (id_is_div),
    .hz_o          (w_hz)
  );

  assign w_active = (state_q != S_IDLE);

  // WB owns the EX/MEM slot, so any EX instruction must replay next cycle.
  assign stall = (w_active && w_hz) ||
                 ((state_q == S_WB) && ex_valid) ||
                 (w_active && ex_div_valid);
`else
  logic w_unused_id;

  assign w_unused_id = ^{ex_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
                         id_rd, id_wr_en, id_is_div};

  assign stall = (state_q != S_IDLE);
`endif

endmodule

`default_nettype wire

// File: tb/tb_div_wb_ctrl.sv
// tb_div_wb_ctrl: directed self-checking bench for div_wb_ctrl (DIV_LAT=33);
// stall expectations follow DIV_OVERLAP_EN when it is defined.
`default_nettype none

module tb_div_wb_ctrl;

  localparam int L = 33;
`ifdef DIV_OVERLAP_EN
  localparam logic OVL = 1'b1;
`else
  localparam logic OVL = 1'b0;
`endif
  // stall expected while a divide is active and ID is independent of it
  localparam logic EXP_INDEP = OVL ? 1'b0 : 1'b1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ex_div_valid;
  logic [1:0] ex_div_op;
  logic [4:0] ex_div_rd;
  logic       ex_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_wr_en, id_is_div;
  logic       div_start, IDiv, div_done, div_busy, stall;
  logic [1:0] div_op;
  logic [4:0] recon_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_wb_ctrl #(.DIV_LAT(L), .XLEN(32)) dut (
    .CLK          (clk),
    .rst_n        (rst_n),
    .ex_div_valid (ex_div_valid),
    .ex_div_op    (ex_div_op),
    .ex_div_rd    (ex_div_rd),
    .ex_valid     (ex_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_wr_en     (id_wr_en),
    .id_is_div    (id_is_div),
    .div_start    (div_start),
    .div_op       (div_op),
    .IDiv         (IDiv),
    .div_done     (div_done),
    .recon_rd     (recon_rd),
    .div_busy     (div_busy),
    .stall        (stall)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic wr, input logic isd);
    id_rs1 = rs1; id_rs1_used = u1;
    id_rs2 = rs2; id_rs2_used = u2;
    id_rd  = rd;  id_wr_en    = wr;
    id_is_div = isd;
  endtask

  initial begin
    int n;
    int sbad;
    logic exp_st;

    rst_n = 1'b0;
    ex_div_valid = 1'b0; ex_div_op = 2'd0; ex_div_rd = 5'd0; ex_valid = 1'b0;
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

    // Reset state
    repeat (2) cyc();
    #1;
    chk("rst_start",  {7'd0, div_start}, 8'd0);
    chk("rst_done",   {7'd0, div_done},  8'd0);
    chk("rst_busy",   {7'd0, div_busy},  8'd0);
    chk("rst_stall",  {7'd0, stall},     8'd0);
    chk("rst_rd",     {3'd0, recon_rd},  8'd0);
    chk("rst_op",     {6'd0, div_op},    8'd0);
    rst_n = 1'b1;
    cyc();

    // Basic DIVU rd=5: start at t, done only at t+34
    ex_div_valid = 1'b1; ex_div_op = 2'd1; ex_div_rd = 5'd5;
    #1;
    chk("t1_start", {7'd0, div_start}, 8'd1);
    chk("t1_idiv",  {7'd0, IDiv},      8'd1);
    chk("t1_busy0", {7'd0, div_busy},  8'd0);
    chk("t1_stall0",{7'd0, stall},     8'd0);
    cyc();
    ex_div_valid = 1'b0;
    #1;
    chk("t1_busy",  {7'd0, div_busy},  8'd1);
    chk("t1_rd",    {3'd0, recon_rd},  8'd5);
    chk("t1_op",    {6'd0, div_op},    8'd1);
    chk("t1_nostart", {7'd0, div_start}, 8'd0);
    chk("t1_stall", {7'd0, stall},     {7'd0, EXP_INDEP});
    for (int k = 2; k <= L; k++) begin
      cyc();
      chk("t1_done_early", {7'd0, div_done}, 8'd0);
    end
    cyc();
    chk("t1_done",    {7'd0, div_done}, 8'd1);
    chk("t1_wb_busy", {7'd0, div_busy}, 8'd1);
    chk("t1_wb_stall",{7'd0, stall},    {7'd0, EXP_INDEP});
    cyc();
    chk("t1_done_off",{7'd0, div_done}, 8'd0);
    chk("t1_idle",    {7'd0, div_busy}, 8'd0);
    chk("t1_idle_stall", {7'd0, stall}, 8'd0);

    // REM rd=7 with a varying ID instruction stream
    ex_div_valid = 1'b1; ex_div_op = 2'd2; ex_div_rd = 5'd7;
    #1;
    chk("t2_start", {7'd0, div_start}, 8'd1);
    cyc();
    ex_div_valid = 1'b0;
    for (int k = 1; k <= L; k++) begin
      if (k <= 5) begin
        set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0); exp_st = EXP_INDEP;
      end else if (k <= 10) begin
        set_id(5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0); exp_st = 1'b1;
      end else if (k <= 15) begin
        set_id(5'd1, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0); exp_st = 1'b1;
      end else if (k <= 20) begin
        set_id(5'd1, 1'b1, 5'd7, 1'b0, 5'd9, 1'b1, 1'b0); exp_st = EXP_INDEP;
      end else if (k <= 25) begin
        set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0); exp_st = 1'b1;
      end else begin
        set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b0, 1'b1); exp_st = 1'b1;
      end
      #1;
      chk("t2_stall", {7'd0, stall}, {7'd0, exp_st});
      chk("t2_done_early", {7'd0, div_done}, 8'd0);
      cyc();
    end
    set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
    ex_valid = 1'b1;
    #1;
    chk("t2_wb_done",  {7'd0, div_done}, 8'd1);
    chk("t2_wb_stall", {7'd0, stall},    8'd1);
    cyc();
    set_id(5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1);
    #1;
    chk("t2_post_stall", {7'd0, stall},    8'd0);
    chk("t2_post_done",  {7'd0, div_done}, 8'd0);
    chk("t2_post_busy",  {7'd0, div_busy}, 8'd0);
    ex_valid = 1'b0;
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

    // REMU rd=3, then a DIV rd=4 waits in EX until the first IDLE cycle
    ex_div_valid = 1'b1; ex_div_op = 2'd3; ex_div_rd = 5'd3;
    #1;
    chk("t3_start", {7'd0, div_start}, 8'd1);
    cyc();
    ex_div_op = 2'd0; ex_div_rd = 5'd4;
    for (int k = 1; k <= L; k++) begin
      #1;
      chk("t3_no_start", {7'd0, div_start}, 8'd0);
      chk("t3_hold",     {7'd0, stall},     8'd1);
      if (k == 1) begin
        chk("t3_rd",  {3'd0, recon_rd}, 8'd3);
        chk("t3_op",  {6'd0, div_op},   8'd3);
      end
      cyc();
    end
    #1;
    chk("t3_wb_done",  {7'd0, div_done},  8'd1);
    chk("t3_wb_start", {7'd0, div_start}, 8'd0);
    chk("t3_wb_stall", {7'd0, stall},     8'd1);
    cyc();
    chk("t3_restart",  {7'd0, div_start}, 8'd1);
    chk("t3_idiv",     {7'd0, IDiv},      8'd1);
    chk("t3_rs_stall", {7'd0, stall},     8'd0);
    cyc();
    ex_div_valid = 1'b0;
    #1;
    chk("t3_rd2", {3'd0, recon_rd}, 8'd4);
    chk("t3_op2", {6'd0, div_op},   8'd0);
    chk("t3_busy2", {7'd0, div_busy}, 8'd1);
    repeat (L) cyc();
    chk("t3_done2", {7'd0, div_done}, 8'd1);
    cyc();

    // rd=0 divide with an ID instruction reading/writing x0 and being a divide
    ex_div_valid = 1'b1; ex_div_op = 2'd0; ex_div_rd = 5'd0;
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1);
    #1;
    chk("t4_start", {7'd0, div_start}, 8'd1);
    cyc();
    ex_div_valid = 1'b0;
    n = 0;
    sbad = 0;
    for (int k = 1; k <= 40; k++) begin
      #1;
      if (div_done === 1'b1) n++;
      if ((k <= L + 1) && (stall !== EXP_INDEP)) sbad++;
      if ((k > L + 1) && (stall !== 1'b0)) sbad++;
      cyc();
    end
    chk("t4_done_count", n[7:0], 8'd1);
    chk("t4_stall_bad",  sbad[7:0], 8'd0);
    chk("t4_rd", {3'd0, recon_rd}, 8'd0);
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

    // Reset at t+10 drops the in-flight divide
    ex_div_valid = 1'b1; ex_div_op = 2'd1; ex_div_rd = 5'd6;
    #1;
    chk("t5_start", {7'd0, div_start}, 8'd1);
    cyc();
    ex_div_valid = 1'b0;
    repeat (9) cyc();
    rst_n = 1'b0;
    #1;
    chk("t5_busy",  {7'd0, div_busy}, 8'd0);
    chk("t5_stall", {7'd0, stall},    8'd0);
    chk("t5_rd",    {3'd0, recon_rd}, 8'd0);
    chk("t5_op",    {6'd0, div_op},   8'd0);
    cyc();
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 2 * L; k++) begin
      #1;
      if (div_done !== 1'b0) n++;
      cyc();
    end
    chk("t5_no_done", n[7:0], 8'd0);
    chk("t5_idle",    {7'd0, div_busy}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
